ahb_lite_master_arbiter: RTL and testbench

Shares one AHB-Lite master port between two internal requesters, each issuing single-word read/write commands over a valid/ready handshake. Round-robin arbitration picks the next requester. The block sequences the AHB-Lite address and data phases, including HREADY wait states and the two-cycle HRESP error response, then returns read data and status to the requester that issued the command. It sits between the requester logic and the HADDR/HTRANS/HWDATA/HRDATA bus bundle of the AHB-Lite interface.

---
 rtl/ahb_lite_master_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ahb_lite_master_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master_arbiter.sv
// Purpose : round-robin share of one AHB-Lite master port between two single-word requesters.
// Latency : handshake -> rsp_done in 3 cycles, plus one cycle per HREADY=0 cycle in ADDR or DATA.
// Backpr. : one transfer in flight; req_ready is high only in IDLE, so requesters stall while busy.
//
// Ports:
//   HCLK, HRESET              bus clock, asynchronous active-high reset
//   req_valid/req_ready[1:0]  per-requester command handshake (ready is combinational)
//   req_write[1:0]            per-requester direction, 1 = write
//   req_addr0/1, req_wdata0/1 per-requester byte address and write data
//   rsp_done[1:0]             one-cycle completion pulse to the owning requester
//   rsp_err, rsp_rdata        status and read data, held until the next completion
//   HADDR..HWDATA             AHB-Lite master outputs
//   HRDATA, HREADY, HRESP     AHB-Lite slave response
module ahb_lite_master_arbiter #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_write,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  output logic [1:0]  rsp_done,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_idx_q, grant_idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [1:0]  done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  grant;
  logic        hs_vld;
  logic        hs_sel;

  // Round-robin: a lone request wins outright; on contention the requester
  // that did not win last time goes next. last_grant resets to 1 so that
  // requester 0 wins the first contention.
  always_comb begin
    grant = 2'b00;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Ready is gated by reset too: the state flop already reads IDLE while
  // reset is held, but no command may be accepted until it is released.
  assign req_ready = ((state_q == ST_IDLE) && !HRESET) ? grant : 2'b00;
  assign hs_vld    = |req_ready;
  assign hs_sel    = req_ready[1];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_idx_d  = grant_idx_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    done_d       = 2'b00;
    err_d        = err_q;
    rdata_d      = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (hs_vld) begin
          // Word transfers only: the byte offset is dropped at latch time.
          addr_d       = hs_sel ? {req_addr1[31:2], 2'b00} : {req_addr0[31:2], 2'b00};
          wdata_d      = hs_sel ? req_wdata1 : req_wdata0;
          write_d      = req_write[hs_sel];
          grant_idx_d  = hs_sel;
          last_grant_d = hs_sel;
          state_d      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // The first error cycle has HREADY=0 and simply waits here; the
        // transfer completes on the second cycle carrying HRESP=1.
        if (HREADY) begin
          done_d  = grant_idx_q ? 2'b10 : 2'b01;
          err_d   = HRESP;
          rdata_d = write_q ? 32'h0 : HRDATA;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    htrans_d = (state_d == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_idx_q  <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      write_q      <= 1'b0;
      htrans_q     <= HTRANS_IDLE;
      done_q       <= 2'b00;
      err_q        <= 1'b0;
      rdata_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_idx_q  <= grant_idx_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      htrans_q     <= htrans_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  // Address, direction and write data stay parked on their latches outside
  // their own phase; the slave qualifies them with HTRANS and the phase.
  assign HADDR     = addr_q;
  assign HWRITE    = write_q;
  assign HWDATA    = wdata_q;
  assign HTRANS    = htrans_q;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;

  assign rsp_done  = done_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// Directed bench: stimulus pushes expected completions into a scoreboard,
// a negedge monitor pops and compares each rsp_done pulse (including the
// cycle it arrives in); bus-phase signals are checked inline.
module tb_ahb_lite_master_arbiter;

  logic        HCLK;
  logic        HRESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [1:0]  rsp_done;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]  done;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  ahb_lite_master_arbiter dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .rsp_done   (rsp_done),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .HADDR      (HADDR),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HPROT      (HPROT),
    .HTRANS     (HTRANS),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void expect_rsp(input logic [1:0] d, input logic e,
                                     input logic [31:0] rd, input int c);
    exp_t x;
    x.done  = d;
    x.err   = e;
    x.rdata = rd;
    x.cyc   = c;
    sb_q.push_back(x);
  endfunction

  // Monitor: every completion pulse must match the oldest expected entry.
  always @(negedge HCLK) begin
    if (rsp_done !== 2'b00) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected actual=done=%b cyc=%0d required=no pulse", rsp_done, cyc);
      end else begin
        exp_t x;
        x = sb_q.pop_front();
        if (rsp_done !== x.done || rsp_err !== x.err || rsp_rdata !== x.rdata || cyc != x.cyc) begin
          errors++;
          $display("FAIL rsp_check actual=done=%b err=%b rdata=%h cyc=%0d required=done=%b err=%b rdata=%h cyc=%0d",
                   rsp_done, rsp_err, rsp_rdata, cyc, x.done, x.err, x.rdata, x.cyc);
        end
      end
    end
  end

  // Drive a command for requester r at the current negedge.
  task automatic drive_req(input int r, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd);
    if (r == 0) begin
      req_addr0    = addr;
      req_wdata0   = wd;
      req_write[0] = wr;
      req_valid[0] = 1'b1;
    end else begin
      req_addr1    = addr;
      req_wdata1   = wd;
      req_write[1] = wr;
      req_valid[1] = 1'b1;
    end
  endtask

  // Wait (bounded) for req_ready[r]; c0 is the cycle number of the handshake cycle.
  task automatic handshake(input int r, output int c0);
    logic ok;
    ok = 1'b0;
    c0 = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready[r] === 1'b1) begin
        ok = 1'b1;
        c0 = cyc;
        break;
      end
      @(negedge HCLK);
    end
    chk($sformatf("handshake_req%0d", r), {31'b0, ok}, 32'd1);
  endtask

  initial begin
    int c0;
    int c_err;
    HRESET     = 1'b1;
    req_valid  = 2'b11;
    req_write  = 2'b00;
    req_addr0  = 32'h0;
    req_addr1  = 32'h0;
    req_wdata0 = 32'h0;
    req_wdata1 = 32'h0;
    HRDATA     = 32'h0;
    HREADY     = 1'b1;
    HRESP      = 1'b0;

    // Reset state.
    repeat (2) @(negedge HCLK);
    #1;
    chk("rst_htrans",  {30'b0, HTRANS},   32'h0);
    chk("rst_haddr",   HADDR,             32'h0);
    chk("rst_hwrite",  {31'b0, HWRITE},   32'h0);
    chk("rst_hwdata",  HWDATA,            32'h0);
    chk("rst_done",    {30'b0, rsp_done}, 32'h0);
    chk("rst_err",     {31'b0, rsp_err},  32'h0);
    chk("rst_rdata",   rsp_rdata,         32'h0);
    chk("rst_ready",   {30'b0, req_ready},32'h0);
    chk("const_hsize", {29'b0, HSIZE},    32'h2);
    chk("const_hburst",{29'b0, HBURST},   32'h0);
    chk("const_hprot", {28'b0, HPROT},    32'h3);
    @(negedge HCLK);
    req_valid = 2'b00;
    HRESET    = 1'b0;

    // Contention from reset: grants 0,1,0,1, each ready a one-cycle pulse.
    @(negedge HCLK);
    HRDATA     = 32'h5A5A_1111;
    req_addr0  = 32'h0000_0100;
    req_wdata0 = 32'hA0A0_A0A0;
    req_addr1  = 32'h0000_0200;
    req_wdata1 = 32'hB1B1_B1B1;
    req_write  = 2'b01;
    req_valid  = 2'b11;
    for (int k = 0; k < 12; k++) begin
      logic [1:0] exp_rdy;
      if (k > 0) @(negedge HCLK);
      #1;
      exp_rdy = (k % 3 != 0) ? 2'b00 : (((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("cont_ready_k%0d", k), {30'b0, req_ready}, {30'b0, exp_rdy});
      if (k % 3 == 0) begin
        if (exp_rdy == 2'b01) expect_rsp(2'b01, 1'b0, 32'h0, cyc + 3);
        else                  expect_rsp(2'b10, 1'b0, 32'h5A5A_1111, cyc + 3);
      end
    end
    @(negedge HCLK);
    req_valid = 2'b00;

    // Single write, zero wait states.
    @(negedge HCLK);
    drive_req(0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
    handshake(0, c0);
    expect_rsp(2'b01, 1'b0, 32'h0, c0 + 3);
    @(negedge HCLK);
    req_valid = 2'b00;
    #1;
    chk("wr_htrans_c1", {30'b0, HTRANS}, 32'h2);
    chk("wr_haddr_c1",  HADDR,           32'h1000_0004);
    chk("wr_hwrite_c1", {31'b0, HWRITE}, 32'h1);
    @(negedge HCLK);
    #1;
    chk("wr_htrans_c2", {30'b0, HTRANS}, 32'h0);
    chk("wr_hwdata_c2", HWDATA,          32'hDEAD_BEEF);

    // Read with two DATA wait states.
    @(negedge HCLK);
    HRDATA = 32'h0;
    drive_req(1, 1'b0, 32'h0000_0020, 32'h0);
    handshake(1, c0);
    expect_rsp(2'b10, 1'b0, 32'h1234_5678, c0 + 5);
    @(negedge HCLK);
    req_valid = 2'b00;
    #1;
    chk("rd_htrans_c1", {30'b0, HTRANS}, 32'h2);
    chk("rd_haddr_c1",  HADDR,           32'h20);
    chk("rd_hwrite_c1", {31'b0, HWRITE}, 32'h0);
    @(negedge HCLK);
    HREADY = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    HREADY = 1'b1;
    HRDATA = 32'h1234_5678;
    @(negedge HCLK);
    HRDATA = 32'h0;

    // Two-cycle error response on a write.
    @(negedge HCLK);
    drive_req(1, 1'b1, 32'h0000_0044, 32'h5555_AAAA);
    handshake(1, c_err);
    expect_rsp(2'b10, 1'b1, 32'h0, c_err + 4);
    @(negedge HCLK);
    req_valid = 2'b00;
    @(negedge HCLK);
    HREADY = 1'b0;
    HRESP  = 1'b1;
    #1;
    chk("err_htrans_c2", {30'b0, HTRANS}, 32'h0);
    @(negedge HCLK);
    HREADY = 1'b1;
    HRESP  = 1'b1;
    @(negedge HCLK);
    HRESP  = 1'b0;

    // Address-phase stall with a misaligned address, issued in the error's
    // completion cycle to show the FSM is already back in IDLE.
    drive_req(0, 1'b0, 32'h0000_1003, 32'h0);
    handshake(0, c0);
    chk("err_back_idle", c0 - c_err, 32'd4);
    expect_rsp(2'b01, 1'b0, 32'h7777_1003, c0 + 6);
    @(negedge HCLK);
    req_valid = 2'b00;
    HREADY    = 1'b0;
    #1;
    chk("err_held", {31'b0, rsp_err}, 32'h1);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge HCLK);
      if (k == 4) HREADY = 1'b1;
      #1;
      chk($sformatf("stall_htrans_c%0d", k), {30'b0, HTRANS}, 32'h2);
      chk($sformatf("stall_haddr_c%0d", k),  HADDR,           32'h0000_1000);
    end
    @(negedge HCLK);
    HRDATA = 32'h7777_1003;
    #1;
    chk("stall_htrans_c5", {30'b0, HTRANS}, 32'h0);
    @(negedge HCLK);
    HRDATA = 32'h0;

    // Reset asserted in DATA: no completion, requester 0 wins afterwards.
    @(negedge HCLK);
    drive_req(0, 1'b1, 32'h0000_0300, 32'h0000_0011);
    handshake(0, c0);
    @(negedge HCLK);
    req_valid = 2'b00;
    #1;
    chk("rstm_htrans_c1", {30'b0, HTRANS}, 32'h2);
    @(negedge HCLK);
    HREADY = 1'b0;
    @(negedge HCLK);
    HRESET    = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("rstm_htrans", {30'b0, HTRANS},    32'h0);
    chk("rstm_done",   {30'b0, rsp_done},  32'h0);
    chk("rstm_haddr",  HADDR,              32'h0);
    chk("rstm_hwdata", HWDATA,             32'h0);
    chk("rstm_ready",  {30'b0, req_ready}, 32'h0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    HREADY = 1'b1;
    #1;
    chk("rstm_first_grant", {30'b0, req_ready}, 32'h1);
    expect_rsp(2'b01, 1'b0, 32'h0, cyc + 3);
    @(negedge HCLK);
    req_valid = 2'b00;

    repeat (6) @(negedge HCLK);
    #1;
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
